// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and port ownership.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_streak_counter.sv
// Saturating count of consecutive D grants taken while a fetch was waiting.
module arb_streak_counter #(
    parameter int D_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CNT_W = $clog2(D_STREAK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(D_STREAK_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported multi-cycle memory between instruction fetch (I)
// and the memory stage (D); one access in flight, per-port done/stall.
//
// state  | meaning
// IDLE   | no access in flight; issue winner combinationally this cycle
// BUSY_I | fetch in flight; a flush marks it killed so its data is dropped
// BUSY_D | load/store in flight; done passes straight through from memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    arb_state_e        state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              i_live;
    logic              owner;
    logic              streak_sat;
    logic              streak_inc;
    logic              streak_clr;
    logic [ADDR_W-1:0] win_addr;
    logic              win_wr;
    logic [DATA_W-1:0] win_wdata;

    // A fetch being squashed this very cycle must not be issued or win arbitration.
    assign i_live = i_req & ~i_flush;
    assign owner  = (d_req && !(i_live && streak_sat)) ? OWN_D : OWN_I;

    assign win_addr  = (owner == OWN_D) ? d_addr : i_addr;
    assign win_wr    = (owner == OWN_D) & d_wr;
    assign win_wdata = (owner == OWN_D) ? d_wdata : '0;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        mem_en     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (i_live || d_req) begin
                    mem_en = 1'b1;
                    if (owner == OWN_D) begin
                        state_d    = BUSY_D;
                        streak_inc = i_req;
                        streak_clr = ~i_req;
                    end else begin
                        state_d    = BUSY_I;
                        streak_clr = 1'b1;
                    end
                end
            end
            BUSY_I: begin
                if (i_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_done) begin
                    i_done  = ~kill_q & ~i_flush;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_done) begin
                    d_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outside an issue cycle the bus shows the last issued access (don't-care to memory).
    assign mem_addr  = mem_en ? win_addr  : addr_q;
    assign mem_wr    = mem_en ? win_wr    : wr_q;
    assign mem_wdata = mem_en ? win_wdata : wdata_q;

    assign i_rdata = i_done ? mem_rdata : '0;
    assign d_rdata = d_done ? mem_rdata : '0;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (mem_en) begin
                addr_q  <= win_addr;
                wr_q    <= win_wr;
                wdata_q <= win_wdata;
            end
        end
    end

    arb_streak_counter #(
        .D_STREAK_MAX(D_STREAK_MAX)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc_i (streak_inc),
        .clr_i (streak_clr),
        .sat_o (streak_sat)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency (L=4) memory model.
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, i_done, i_stall;
    logic [15:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_done, d_stall;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_done = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .D_STREAK_MAX(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    // Memory model: fixed contents plus one write-back word; ignores rst on purpose.
    int          rem = 0;
    logic [15:0] rd_q = 16'h0000;
    logic [15:0] st_addr_q = 16'hFFFF;
    logic [15:0] st_data_q = 16'h0000;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hA5A5;
            16'h1000: return 16'h5A5A;
            16'h0080: return 16'hBEEF;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            rem      <= L - 1;
            mem_done <= 1'b0;
            rd_q     <= (mem_addr == st_addr_q) ? st_data_q : rom(mem_addr);
            if (mem_wr) begin
                st_addr_q <= mem_addr;
                st_data_q <= mem_wdata;
            end
        end else if (rem != 0) begin
            rem      <= rem - 1;
            mem_done <= (rem == 1);
        end else begin
            mem_done <= 1'b0;
        end
    end
    assign mem_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_en"},  32'(mem_en),    32'h0);
        chk({tag, "_mem_wr"},  32'(mem_wr),    32'h0);
        chk({tag, "_addr"},    32'(mem_addr),  32'h0);
        chk({tag, "_wdata"},   32'(mem_wdata), 32'h0);
        chk({tag, "_i_done"},  32'(i_done),    32'h0);
        chk({tag, "_d_done"},  32'(d_done),    32'h0);
        chk({tag, "_i_rdata"}, 32'(i_rdata),   32'h0);
        chk({tag, "_d_rdata"}, 32'(d_rdata),   32'h0);
        chk({tag, "_i_stall"}, 32'(i_stall),   32'h0);
        chk({tag, "_d_stall"}, 32'(d_stall),   32'h0);
    endtask

    logic [5:0] seq_d;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) nxt();
        #1;
        chk_quiet("reset");
        nxt(); rst = 1'b0;

        // single fetch
        nxt(); i_req = 1'b1; i_addr = 16'h0040; #1;
        chk("f_mem_en", 32'(mem_en), 32'h1);
        chk("f_mem_wr", 32'(mem_wr), 32'h0);
        chk("f_addr", 32'(mem_addr), 32'h0040);
        chk("f_stall0", 32'(i_stall), 32'h1);
        for (int k = 1; k < 4; k++) begin
            nxt(); #1;
            chk($sformatf("f_stall%0d", k), 32'(i_stall), 32'h1);
            chk($sformatf("f_nodone%0d", k), 32'(i_done), 32'h0);
        end
        nxt(); #1;
        chk("f_done", 32'(i_done), 32'h1);
        chk("f_rdata", 32'(i_rdata), 32'hA5A5);
        chk("f_stall_end", 32'(i_stall), 32'h0);
        nxt(); i_req = 1'b0; #1;
        chk("f_idle", 32'(mem_en), 32'h0);

        // contention: D first, then I one idle cycle later
        nxt(); i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1000; #1;
        chk("c_mem_en", 32'(mem_en), 32'h1);
        chk("c_addr_d", 32'(mem_addr), 32'h1000);
        chk("c_mem_wr", 32'(mem_wr), 32'h0);
        repeat (3) nxt();
        nxt(); #1;
        chk("c_d_done", 32'(d_done), 32'h1);
        chk("c_d_rdata", 32'(d_rdata), 32'h5A5A);
        chk("c_i_wait", 32'(i_done), 32'h0);
        nxt(); d_req = 1'b0; #1;
        chk("c_i_issue", 32'(mem_en), 32'h1);
        chk("c_addr_i", 32'(mem_addr), 32'h0040);
        repeat (3) nxt();
        nxt(); #1;
        chk("c_i_done", 32'(i_done), 32'h1);
        chk("c_i_rdata", 32'(i_rdata), 32'hA5A5);
        nxt(); i_req = 1'b0;

        // starvation guard, D_STREAK_MAX = 2: D D I D D I
        seq_d = 6'b011011;
        nxt(); i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1000;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) nxt();
            #1;
            chk($sformatf("s_en%0d", k), 32'(mem_en), 32'h1);
            chk($sformatf("s_grant%0d", k), 32'(mem_addr), seq_d[k] ? 32'h1000 : 32'h0040);
            repeat (3) nxt();
            nxt(); #1;
            chk($sformatf("s_done%0d", k), 32'(seq_d[k] ? d_done : i_done), 32'h1);
        end
        nxt(); i_req = 1'b0; d_req = 1'b0;

        // flush mid-flight, refetch, then flush coincident with mem_done, then flush in IDLE
        nxt(); i_req = 1'b1; i_addr = 16'h0040; #1;
        chk("x_issue", 32'(mem_en), 32'h1);
        nxt();
        nxt(); i_flush = 1'b1;
        nxt(); i_flush = 1'b0; i_addr = 16'h0080;
        nxt(); #1;
        chk("x_killed", 32'(i_done), 32'h0);
        chk("x_stall", 32'(i_stall), 32'h1);
        nxt(); #1;
        chk("x_reissue", 32'(mem_en), 32'h1);
        chk("x_addr", 32'(mem_addr), 32'h0080);
        repeat (3) nxt();
        nxt(); #1;
        chk("x_done", 32'(i_done), 32'h1);
        chk("x_rdata", 32'(i_rdata), 32'hBEEF);
        nxt(); i_addr = 16'h0040; #1;
        chk("x2_issue", 32'(mem_en), 32'h1);
        repeat (3) nxt();
        nxt(); i_flush = 1'b1; #1;
        chk("x2_flush_at_done", 32'(i_done), 32'h0);
        nxt(); #1;
        chk("x2_idle_flush", 32'(mem_en), 32'h0);
        nxt(); i_req = 1'b0; i_flush = 1'b0;

        // store, read back, then a store cut short by reset
        nxt(); d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2002; d_wdata = 16'h1234; #1;
        chk("w_en", 32'(mem_en), 32'h1);
        chk("w_wr", 32'(mem_wr), 32'h1);
        chk("w_addr", 32'(mem_addr), 32'h2002);
        chk("w_wdata", 32'(mem_wdata), 32'h1234);
        repeat (3) nxt();
        nxt(); #1;
        chk("w_done", 32'(d_done), 32'h1);
        nxt(); d_req = 1'b0; d_wr = 1'b0;
        nxt(); d_req = 1'b1; #1;
        chk("r_en", 32'(mem_en), 32'h1);
        chk("r_wr", 32'(mem_wr), 32'h0);
        repeat (3) nxt();
        nxt(); #1;
        chk("r_done", 32'(d_done), 32'h1);
        chk("r_rdata", 32'(d_rdata), 32'h1234);
        nxt(); d_req = 1'b0;

        nxt(); d_req = 1'b1; d_wr = 1'b1; d_wdata = 16'h5678; #1;
        chk("w2_en", 32'(mem_en), 32'h1);
        nxt();
        nxt(); rst = 1'b1; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        nxt(); rst = 1'b0; #1;
        chk("w2_idle_en", 32'(mem_en), 32'h0);
        chk("w2_idle_done", 32'(d_done), 32'h0);
        nxt(); #1;
        chk("w2_stale_seen", 32'(mem_done), 32'h1);
        chk_quiet("w2_stale");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
